mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multi-cycle control sequencer for the MIPS decode/execute datapath. It steps each instruction through fetch, decode, execute, memory and write-back states and drives every datapath select and write-enable. These signals cover PC, IR, register file, ALU and memory port, so `execute_unit`-style datapaths no longer complete an instruction combinationally in one clock. It also handshakes with a variable-latency memory and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep sequencing, 0 = park in IDLE after the current instruction
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  write/strobe enables
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- alu_src_a  out  1  0 PC, 1 busA
- alu_src_b  out  2  00 busB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- state  out  4  current state code
- illegal  out  1  one-cycle pulse on an unsupported instruction
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Supported instructions: R-type (opcode 0) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Anything else, including opcode 0 with an unknown funct, is illegal.
- States, with encodings:
  - IDLE 0, FETCH 1, DECODE 2
  - EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7
  - WB_R 8, WB_MEM 9, WB_I 10, BRANCH 11, JUMP 12
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1; the state then goes to DECODE. Otherwise FETCH holds.
- DECODE:
  - Asserts alu_src_a=0, alu_src_b=11, alu_ctrl=add, so the branch target goes into ALUOut.
  - Next state by opcode: R → EXEC_R, lw/sw → MEM_ADDR, addi → EXEC_I, beq → BRANCH, j → JUMP.
  - Illegal: illegal=1 for this cycle, then FETCH (or IDLE if run=0).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct → WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=10, add → WB_I.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; holds until mem_ready → WB_MEM.
- MEM_WR: mem_write=1, iord=1; holds until mem_ready, then the instruction completes.
- Write-back states:
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=alu_zero.
- JUMP: pc_write=1, pc_src=10.
- Completion:
  - Completing states: WB_R, WB_MEM, WB_I, MEM_WR (with mem_ready), BRANCH, JUMP.
  - On leaving a completing state, instr_count increments by 1, then FETCH if run=1 else IDLE.
  - Illegal instructions are not counted.
- run=0 mid-instruction never aborts; it only takes effect at completion or from IDLE.

## Timing
- State and counter are registered. Outputs are combinational from state, plus opcode/funct/alu_zero/mem_ready where stated above.
- Reset: asynchronous assertion forces IDLE and instr_count=0. Every output is 0 during and after reset until run=1.
- Reset mid-instruction (for example in MEM_WR) drops all strobes immediately, with no partial write.
- Cycles per instruction with mem_ready tied 1, FETCH through completion:
  - R 4, addi 4, sw 4, lw 5, beq 3, j 3, illegal 2.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle. Strobes stay stable while waiting.
- instr_count updates on the clock edge that leaves the completing state. Wrap: all-ones → 0.

## Test plan
- Reset then run=1, opcode 0, funct 0x20, mem_ready=1 → states 1,2,3,8. reg_write=1 and reg_dst=1 only in state 8. instr_count 0→1.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD → 7-cycle instruction. mem_read and iord held 1 for 3 cycles. WB_MEM has mem_to_reg=1.
- beq with alu_zero=1, then beq with alu_zero=0 → pc_write=1 with pc_src=01 in the first; pc_write=0 in the second. Both count; instr_count +2.
- opcode 0x3F, then opcode 0 with funct 0x07 → illegal pulses 1 cycle each in DECODE, return to FETCH, instr_count unchanged.
- run dropped during EXEC_R → WB_R completes, then IDLE with all outputs 0. Re-asserting run → FETCH next cycle.
- RST_N low asynchronously while in MEM_WR with mem_ready=0 → mem_write falls before the next edge, state=0, instr_count=0.

Source files
------------

// File: rtl/mips_mc_control.sv
// mips_mc_control
//
// Multi-cycle control sequencer for the MIPS decode/execute datapath. Each instruction
// is stepped through FETCH, DECODE, an execute/address state, an optional memory state
// and a write-back (or branch/jump) state. Every datapath select and write-enable is
// produced here. Memory accesses handshake on mem_ready, so latency can vary. Retired
// instructions are counted; illegal instructions are flagged and not counted.
//
// Ports
//   CLK          in   rising-edge clock
//   RST_N        in   asynchronous active-low reset (forces IDLE, clears counter)
//   run          in   1 = keep sequencing, 0 = park in IDLE at the next completion
//   mem_ready    in   memory access completes in a cycle where this is 1
//   opcode       in   IR[31:26]
//   funct        in   IR[5:0]
//   alu_zero     in   ALU zero flag (beq decision)
//   pc_write     out  PC write enable
//   ir_write     out  IR write enable
//   reg_write    out  register file write enable
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   iord         out  memory address select: 0 PC, 1 ALUOut
//   reg_dst      out  destination register: 0 rt, 1 rd
//   mem_to_reg   out  write-back data: 0 ALUOut, 1 MDR
//   alu_src_a    out  ALU A: 0 PC, 1 busA
//   alu_src_b    out  ALU B: 00 busB, 01 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_ctrl     out  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//   pc_src       out  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   state        out  current state code
//   illegal      out  one-cycle pulse in DECODE on an unsupported instruction
//   instr_count  out  retired-instruction count, wraps modulo 2^CNT_W

module mips_mc_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    // ALU operations
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluSlt = 4'b0111;

    // ALU B operand selects
    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    // PC sources
    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StExecR   = 4'd3,
        StExecI   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWr   = 4'd7,
        StWbR     = 4'd8,
        StWbMem   = 4'd9,
        StWbI     = 4'd10,
        StBranch  = 4'd11,
        StJump    = 4'd12
    } state_e;

    state_e           stateQ, stateD;
    logic [CNT_W-1:0] countQ, countD;
    logic             retire;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic isRtype, isLw, isSw, isBeq, isAddi, isJ;
    logic functLegal, instrIllegal;
    logic [3:0] rAluOp;

    always_comb begin
        isRtype = (opcode == OpRtype);
        isLw    = (opcode == OpLw);
        isSw    = (opcode == OpSw);
        isBeq   = (opcode == OpBeq);
        isAddi  = (opcode == OpAddi);
        isJ     = (opcode == OpJ);
    end

    always_comb begin
        functLegal = 1'b1;
        rAluOp     = AluAdd;
        case (funct)
            FnAdd:   rAluOp = AluAdd;
            FnSub:   rAluOp = AluSub;
            FnAnd:   rAluOp = AluAnd;
            FnOr:    rAluOp = AluOr;
            FnSlt:   rAluOp = AluSlt;
            default: functLegal = 1'b0;
        endcase
    end

    assign instrIllegal = !((isRtype && functLegal) || isLw || isSw || isBeq || isAddi || isJ);

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    state_e afterDone;

    // Where every completing state (and an illegal DECODE) goes next.
    assign afterDone = run ? StFetch : StIdle;

    always_comb begin
        stateD     = stateQ;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_ctrl   = AluAnd;
        pc_src     = PcAlu;
        illegal    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (run) begin
                    stateD = StFetch;
                end
            end

            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                alu_ctrl  = AluAdd;
                // IR load and PC+4 happen together on the cycle the read completes.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    stateD   = StDecode;
                end
            end

            StDecode: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = SrcBImmSh;
                alu_ctrl  = AluAdd;
                if (instrIllegal) begin
                    illegal = 1'b1;
                    stateD  = afterDone;
                end else if (isRtype) begin
                    stateD = StExecR;
                end else if (isLw || isSw) begin
                    stateD = StMemAddr;
                end else if (isAddi) begin
                    stateD = StExecI;
                end else if (isBeq) begin
                    stateD = StBranch;
                end else begin
                    stateD = StJump;
                end
            end

            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBReg;
                alu_ctrl  = rAluOp;
                stateD    = StWbR;
            end

            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_ctrl  = AluAdd;
                stateD    = StWbI;
            end

            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_ctrl  = AluAdd;
                stateD    = isSw ? StMemWr : StMemRd;
            end

            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    stateD = StWbMem;
                end
            end

            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    stateD = afterDone;
                end
            end

            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                stateD    = afterDone;
            end

            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                stateD     = afterDone;
            end

            StWbI: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                stateD    = afterDone;
            end

            StBranch: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBReg;
                alu_ctrl  = AluSub;
                pc_src    = PcAluOut;
                pc_write  = alu_zero;
                retire    = 1'b1;
                stateD    = afterDone;
            end

            StJump: begin
                pc_write = 1'b1;
                pc_src   = PcJump;
                retire   = 1'b1;
                stateD   = afterDone;
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign countD = countQ + {{(CNT_W-1){1'b0}}, retire};

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateQ <= StIdle;
            countQ <= '0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
        end
    end

    assign state       = stateQ;
    assign instr_count = countQ;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: reset checks, a directed table of
// instructions measured by observed cycle count / retirements / pulses, an async
// reset in the middle of a store, and a randomized run against a per-instruction
// step model built from the instruction-level timing rules.

module tb_mips_mc_control;

    localparam int CW = 4;  // small counter so wrap is reached quickly

    logic          CLK, RST_N, run, mem_ready, alu_zero;
    logic [5:0]    opcode, funct;
    logic          pc_write, ir_write, reg_write, mem_read, mem_write, iord;
    logic          reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0]    alu_src_b, pc_src;
    logic [3:0]    alu_ctrl, state;
    logic [CW-1:0] instr_count;
    logic [17:0]   outsVec;

    mips_mc_control #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .run(run), .mem_ready(mem_ready),
        .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .state(state), .illegal(illegal), .instr_count(instr_count)
    );

    assign outsVec = {pc_write, ir_write, reg_write, mem_read, mem_write, iord, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal};

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    int nCmp = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output-vector field builders
    localparam logic [17:0] PCW = 18'h20000, IRW = 18'h10000, RGW = 18'h08000;
    localparam logic [17:0] MRD = 18'h04000, MWR = 18'h02000, IORD = 18'h01000;
    localparam logic [17:0] RDST = 18'h00800, M2R = 18'h00400, SRCA = 18'h00200;
    localparam logic [17:0] ILL = 18'h00001;
    function automatic logic [17:0] fB(input logic [1:0] v); return 18'(v) << 7; endfunction
    function automatic logic [17:0] fC(input logic [3:0] v); return 18'(v) << 3; endfunction
    function automatic logic [17:0] fP(input logic [1:0] v); return 18'(v) << 1; endfunction
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

    // Instruction kinds: 0 illegal, 1 R, 2 lw, 3 sw, 4 beq, 5 addi, 6 j
    function automatic int kindOf(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
                             fn == 6'h2A) ? 1 : 0;
            6'h23:   return 2;
            6'h2B:   return 3;
            6'h04:   return 4;
            6'h08:   return 5;
            6'h02:   return 6;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] aluOf(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic        z;
        int          wf;
        int          wm;
        logic        rn;
        int          cyc;
        int          ret;
        int          ill;
        int          pcw;
        logic [3:0]  endSt;
    } vec_t;

    vec_t vecs[14];

    // Starts with the DUT in FETCH; runs one instruction to its next FETCH/IDLE.
    task automatic runDirected(input vec_t v);
        int cyc = 0, ill = 0, pcw = 0, fw = v.wf, mw = v.wm;
        logic [3:0] prev;
        logic [CW-1:0] c0, d;
        bit fin = 0;
        c0 = instr_count;
        while (!fin && cyc < 50) begin
            @(negedge CLK);
            opcode = v.opc; funct = v.fn; alu_zero = v.z; run = v.rn;
            if (state == 4'd1 && fw > 0) begin
                mem_ready = 0; fw--;
            end else if ((state == 4'd6 || state == 4'd7) && mw > 0) begin
                mem_ready = 0; mw--;
            end else begin
                mem_ready = 1;
            end
            #1;
            ill += int'(illegal);
            pcw += int'(pc_write);
            cyc++;
            prev = state;
            @(posedge CLK);
            #1;
            if (prev != 4'd1 && (state == 4'd0 || state == 4'd1)) fin = 1;
        end
        d = instr_count - c0;
        chk({v.name, "_cycles"}, cyc, v.cyc);
        chk({v.name, "_retired"}, 32'(d), v.ret);
        chk({v.name, "_illegal"}, ill, v.ill);
        chk({v.name, "_pcwrites"}, pcw, v.pcw);
        chk({v.name, "_endstate"}, 32'(state), 32'(v.endSt));
        if (state == 4'd0) begin
            @(negedge CLK);
            #1;
            chk({v.name, "_idle_outs"}, 32'(outsVec), 0);
            run = 1;
            @(posedge CLK);
            #1;
            chk({v.name, "_idle_exit"}, 32'(state), 1);
        end
    endtask

    // ------------------------------------------------------------------
    // Randomized step model
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic        z;
        logic        rn;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [17:0] outs;
        bit          cnt;
    } step_t;

    step_t plan[$];
    logic [CW-1:0] mCount;

    // Mode 2 means "don't care, drive random".
    task automatic addStep(input logic [3:0] st, input int rdy, input int z, input int rn,
                           input logic [5:0] op, input logic [5:0] fn,
                           input logic [17:0] o, input bit cnt);
        step_t s;
        s.st = st;
        s.rdy = (rdy == 2) ? 1'($urandom) : 1'(rdy);
        s.z = (z == 2) ? 1'($urandom) : 1'(z);
        s.rn = (rn == 2) ? 1'($urandom) : 1'(rn);
        s.op = op; s.fn = fn; s.outs = o; s.cnt = cnt;
        plan.push_back(s);
    endtask

    task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn);
        int k = kindOf(op, fn);
        int wf = $urandom_range(0, 2);
        int wm = $urandom_range(0, 2);
        int endRun = ($urandom_range(0, 3) != 0) ? 1 : 0;
        int z = $urandom_range(0, 1);
        logic [17:0] fo = MRD | fB(2'b01) | fC(ADD);
        for (int i = 0; i < wf; i++) addStep(4'd1, 0, 2, 2, op, fn, fo, 0);
        addStep(4'd1, 1, 2, 2, op, fn, fo | PCW | IRW, 0);
        if (k == 0) begin
            addStep(4'd2, 2, 2, endRun, op, fn, fB(2'b11) | fC(ADD) | ILL, 0);
        end else begin
            addStep(4'd2, 2, 2, 2, op, fn, fB(2'b11) | fC(ADD), 0);
            case (k)
                1: begin
                    addStep(4'd3, 2, 2, 2, op, fn, SRCA | fC(aluOf(fn)), 0);
                    addStep(4'd8, 2, 2, endRun, op, fn, RGW | RDST, 1);
                end
                2: begin
                    addStep(4'd5, 2, 2, 2, op, fn, SRCA | fB(2'b10) | fC(ADD), 0);
                    for (int i = 0; i < wm; i++) addStep(4'd6, 0, 2, 2, op, fn, MRD | IORD, 0);
                    addStep(4'd6, 1, 2, 2, op, fn, MRD | IORD, 0);
                    addStep(4'd9, 2, 2, endRun, op, fn, RGW | M2R, 1);
                end
                3: begin
                    addStep(4'd5, 2, 2, 2, op, fn, SRCA | fB(2'b10) | fC(ADD), 0);
                    for (int i = 0; i < wm; i++) addStep(4'd7, 0, 2, 2, op, fn, MWR | IORD, 0);
                    addStep(4'd7, 1, 2, endRun, op, fn, MWR | IORD, 1);
                end
                4: addStep(4'd11, 2, z, endRun, op, fn,
                           SRCA | fC(SUB) | fP(2'b01) | (z != 0 ? PCW : 18'h0), 1);
                5: begin
                    addStep(4'd4, 2, 2, 2, op, fn, SRCA | fB(2'b10) | fC(ADD), 0);
                    addStep(4'd10, 2, 2, endRun, op, fn, RGW, 1);
                end
                default: addStep(4'd12, 2, 2, endRun, op, fn, PCW | fP(2'b10), 1);
            endcase
        end
        if (endRun == 0) begin
            addStep(4'd0, 2, 2, 0, op, fn, 18'h0, 0);
            addStep(4'd0, 2, 2, 1, op, fn, 18'h0, 0);
        end
    endtask

    task automatic execPlan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge CLK);
            run = s.rn; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op; funct = s.fn;
            #1;
            chk("rnd_state", 32'(state), 32'(s.st));
            chk("rnd_outs", 32'(outsVec), 32'(s.outs));
            chk("rnd_count", 32'(instr_count), 32'(mCount));
            if (s.cnt) mCount++;
        end
    endtask

    task automatic resetChecks(input string tag);
        @(negedge CLK);
        run = 0;
        #2 RST_N = 0;
        #1;
        chk({tag, "_rst_state"}, 32'(state), 0);
        chk({tag, "_rst_outs"}, 32'(outsVec), 0);
        chk({tag, "_rst_count"}, 32'(instr_count), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1;
        @(posedge CLK);
        #1;
        chk({tag, "_post_rst_state"}, 32'(state), 0);
        chk({tag, "_post_rst_outs"}, 32'(outsVec), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    logic [5:0] rOp, rFn;
    logic [5:0] rFuncts[5];

    initial begin
        RST_N = 0; run = 0; mem_ready = 0; alu_zero = 0; opcode = 0; funct = 0;
        //          name         opc    fn     z  wf wm rn cyc ret ill pcw end
        vecs[0]  = '{"add",      6'h00, 6'h20, 0, 0, 0, 1, 4, 1, 0, 1, 4'd1};
        vecs[1]  = '{"lw_wait2", 6'h23, 6'h00, 0, 0, 2, 1, 7, 1, 0, 1, 4'd1};
        vecs[2]  = '{"sw_wait",  6'h2B, 6'h00, 0, 1, 1, 1, 6, 1, 0, 1, 4'd1};
        vecs[3]  = '{"beq_tk",   6'h04, 6'h00, 1, 0, 0, 1, 3, 1, 0, 2, 4'd1};
        vecs[4]  = '{"beq_nt",   6'h04, 6'h00, 0, 0, 0, 1, 3, 1, 0, 1, 4'd1};
        vecs[5]  = '{"j",        6'h02, 6'h11, 0, 0, 0, 1, 3, 1, 0, 2, 4'd1};
        vecs[6]  = '{"addi_fw2", 6'h08, 6'h00, 0, 2, 0, 1, 6, 1, 0, 1, 4'd1};
        vecs[7]  = '{"ill_op3f", 6'h3F, 6'h00, 0, 0, 0, 1, 2, 0, 1, 1, 4'd1};
        vecs[8]  = '{"ill_fn07", 6'h00, 6'h07, 0, 0, 0, 1, 2, 0, 1, 1, 4'd1};
        vecs[9]  = '{"sub",      6'h00, 6'h22, 1, 0, 0, 1, 4, 1, 0, 1, 4'd1};
        vecs[10] = '{"slt_stop", 6'h00, 6'h2A, 0, 0, 0, 0, 4, 1, 0, 1, 4'd0};
        vecs[11] = '{"ill_stop", 6'h3F, 6'h00, 0, 0, 0, 0, 2, 0, 1, 1, 4'd0};
        vecs[12] = '{"and_fw1",  6'h00, 6'h24, 0, 1, 0, 1, 5, 1, 0, 1, 4'd1};
        vecs[13] = '{"lw_fast",  6'h23, 6'h25, 1, 0, 0, 1, 5, 1, 0, 1, 4'd1};
        rFuncts[0] = 6'h20; rFuncts[1] = 6'h22; rFuncts[2] = 6'h24;
        rFuncts[3] = 6'h25; rFuncts[4] = 6'h2A;

        // Reset state, held and after release
        #3;
        chk("init_state", 32'(state), 0);
        chk("init_outs", 32'(outsVec), 0);
        chk("init_count", 32'(instr_count), 0);
        resetChecks("boot");

        // Leave IDLE
        @(negedge CLK);
        run = 1;
        @(posedge CLK);
        #1;
        chk("start_fetch", 32'(state), 1);

        foreach (vecs[i]) runDirected(vecs[i]);

        // Store stalled in MEM_WR, then asynchronous reset between edges
        begin
            int guard = 0;
            opcode = 6'h2B; funct = 0; run = 1; mem_ready = 1;
            while (state != 4'd7 && guard < 20) begin
                @(negedge CLK);
                guard++;
            end
            chk("memwr_reached", 32'(state), 7);
            mem_ready = 0;
            #1;
            chk("memwr_strobe", 32'({mem_write, iord}), 32'h3);
            @(posedge CLK);
            #1;
            chk("memwr_hold", 32'({state, mem_write, iord}), 32'h1F);
            @(negedge CLK);
            #2 RST_N = 0;
            #1;
            chk("arst_mem_write", 32'(mem_write), 0);
            chk("arst_state", 32'(state), 0);
            chk("arst_count", 32'(instr_count), 0);
            chk("arst_outs", 32'(outsVec), 0);
            #10;
            @(negedge CLK);
            RST_N = 1;
        end

        // Randomized sequence against the step model
        resetChecks("rnd");
        mCount = 0;
        addStep(4'd0, 2, 2, 1, 6'h00, 6'h20, 18'h0, 0);
        for (int n = 0; n < 90; n++) begin
            int pick = $urandom_range(0, 10);
            rFn = 6'($urandom);
            case (pick)
                0, 1, 2, 3, 4: begin rOp = 6'h00; rFn = rFuncts[$urandom_range(0, 4)]; end
                5: rOp = 6'h23;
                6: rOp = 6'h2B;
                7: rOp = 6'h04;
                8: rOp = 6'h08;
                9: rOp = 6'h02;
                default: begin
                    rOp = 6'($urandom);
                    for (int t = 0; t < 20 && kindOf(rOp, rFn) != 0; t++) begin
                        rOp = 6'($urandom);
                        rFn = 6'($urandom);
                    end
                end
            endcase
            buildInstr(rOp, rFn);
            execPlan();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
